wb_register_file: RTL and testbench
===================================

Name: wb_register_file

Overview:
- Write-back stage plus the architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value.
- Writes that value into a 32x32 register file.
- Serves the two ID-stage read ports and one debug read port.
- Provides write-first internal bypass, so an ID read in the same cycle as a WB write sees the new value.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inLoadWordDividerMEM  input  DATA_W  load data from MEM/WB register (already byte/half aligned and extended).
- inAluLatch  input  DATA_W  ALU result from MEM/WB register.
- inPcPlus8  input  DATA_W  link address for JAL/JALR, carried through MEM/WB.
- inMuxRtRd  input  ADDR_W  destination register number.
- inRegWrite  input  1  write-back enable.
- inMemtoReg  input  2  write-back source select.
- inReadRs  input  ADDR_W  ID-stage read address A.
- inReadRt  input  ADDR_W  ID-stage read address B.
- inDbgAddr  input  ADDR_W  debug read address.
- outRsData  output  DATA_W  read data A.
- outRtData  output  DATA_W  read data B.
- outDbgData  output  DATA_W  debug read data.
- outWbData  output  DATA_W  selected write-back value, also fed to the EX forwarding mux.
- outWbValid  output  1  high when a real register write occurs this cycle.

Behaviour:
- Write-back mux (combinational) on inMemtoReg:
  - 2'b00: inAluLatch
  - 2'b01: inLoadWordDividerMEM
  - 2'b10: inPcPlus8
  - 2'b11: reserved; selects inAluLatch
  - Result drives outWbData.
- outWbValid = inRegWrite && (inMuxRtRd != 0) && !reset.
- Register write:
  - At posedge clk, if outWbValid, regs[inMuxRtRd] <= outWbData.
  - Register 0 is never written and always reads 0.
- Reads are combinational, zero-latency:
  - addr == 0: output 0.
  - addr == inMuxRtRd and outWbValid: output outWbData (write-first bypass).
  - Otherwise: output regs[addr].
  - Bypass applies identically to Rs, Rt and Dbg ports.
  - Rs == Rt with both matching the write address: both ports return outWbData.
- Reset:
  - While reset is high at a posedge, all 32 registers clear to 0 and no write occurs, even if inRegWrite = 1.
  - During reset, read outputs reflect stored values with bypass suppressed. After the reset edge all reads return 0.
  - Reset asserted mid-stream discards the in-flight write of that cycle.
- No stall input: the MEM/WB register handles stall by holding its outputs. A held write re-writes the same value, which is harmless.
- X on inMemtoReg with inRegWrite = 0 must not corrupt any register.
- Storage is a plain register array. No read-during-write hazard other than the specified bypass.

Test Plan:
- Reset then read: assert reset 1 cycle, drive inRegWrite = 1, inMuxRtRd = 5, inAluLatch = 32'hDEAD_BEEF during reset. After reset, inReadRs = 5 -> outRsData = 0, outWbValid was 0.
- Source select: write reg 3 with inMemtoReg = 00/01/10/11 over four cycles (ALU = 32'h11, load = 32'h22, pc8 = 32'h33, ALU = 32'h44). After each edge, inReadRt = 3 -> 32'h11, 32'h22, 32'h33, 32'h44.
- Register zero: inRegWrite = 1, inMuxRtRd = 0, ALU = 32'hFFFF_FFFF -> outWbValid = 0. Read 0 on all ports -> 0, including in the same cycle (no bypass).
- Write-first bypass: reg 7 holds 32'hA. Same cycle write reg 7 <= 32'hB with inReadRs = inReadRt = inDbgAddr = 7 -> all three outputs 32'hB before the edge, and 32'hB after.
- No write when disabled: reg 9 = 32'h55. Drive inRegWrite = 0, inMuxRtRd = 9, ALU = 32'h66 for 3 cycles -> reg 9 stays 32'h55, outWbData = 32'h66, outWbValid = 0.
- Fill/readback: write regs 1..31 with value (i*32'h0101_0101), then read all via Rs, Rt and Dbg -> exact match, reg 0 = 0. Then assert reset for 1 cycle -> all reads 0.

Source files
------------

// File: rtl/wb_register_file.sv
// Write-back stage and 32-entry architectural register file for the 5-stage
// MIPS pipeline: selects the write-back value, commits it, and serves two
// ID-stage read ports plus a debug read port with write-first bypass.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inLoadWordDividerMEM,
    input  logic [DATA_W-1:0] inAluLatch,
    input  logic [DATA_W-1:0] inPcPlus8,
    input  logic [ADDR_W-1:0] inMuxRtRd,
    input  logic              inRegWrite,
    input  logic [1:0]        inMemtoReg,
    input  logic [ADDR_W-1:0] inReadRs,
    input  logic [ADDR_W-1:0] inReadRt,
    input  logic [ADDR_W-1:0] inDbgAddr,
    output logic [DATA_W-1:0] outRsData,
    output logic [DATA_W-1:0] outRtData,
    output logic [DATA_W-1:0] outDbgData,
    output logic [DATA_W-1:0] outWbData,
    output logic              outWbValid
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Register 0 is hardwired to zero; a matching in-flight write wins over
    // the stored value so ID sees the result in the same cycle.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic [ADDR_W-1:0] wrAddr,
        input logic              wrValid,
        input logic [DATA_W-1:0] wrData
    );
        if (addr == '0)
            return '0;
        else if (wrValid && (addr == wrAddr))
            return wrData;
        else
            return stored;
    endfunction

    // Write-back source select and qualification of the register write.
    always_comb begin
        outWbData = inAluLatch;
        case (inMemtoReg)
            2'b01:   outWbData = inLoadWordDividerMEM;
            2'b10:   outWbData = inPcPlus8;
            default: outWbData = inAluLatch;
        endcase
        outWbValid = inRegWrite && (inMuxRtRd != '0) && !reset;
    end

    // Register file update: reset clears everything and drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[ADDR_W'(i)] <= '0;
        end else if (outWbValid) begin
            regs[inMuxRtRd] <= outWbData;
        end
    end

    // Combinational zero-latency read ports with write-first bypass.
    always_comb begin
        outRsData  = readPort(inReadRs,  regs[inReadRs],  inMuxRtRd, outWbValid, outWbData);
        outRtData  = readPort(inReadRt,  regs[inReadRt],  inMuxRtRd, outWbValid, outWbData);
        outDbgData = readPort(inDbgAddr, regs[inDbgAddr], inMuxRtRd, outWbValid, outWbData);
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: table vectors, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inLoadWordDividerMEM, inAluLatch, inPcPlus8;
    logic [4:0]  inMuxRtRd, inReadRs, inReadRt, inDbgAddr;
    logic        inRegWrite;
    logic [1:0]  inMemtoReg;
    logic [31:0] outRsData, outRtData, outDbgData, outWbData;
    logic        outWbValid;

    wb_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .inLoadWordDividerMEM(inLoadWordDividerMEM), .inAluLatch(inAluLatch),
        .inPcPlus8(inPcPlus8), .inMuxRtRd(inMuxRtRd), .inRegWrite(inRegWrite),
        .inMemtoReg(inMemtoReg), .inReadRs(inReadRs), .inReadRt(inReadRt),
        .inDbgAddr(inDbgAddr), .outRsData(outRsData), .outRtData(outRtData),
        .outDbgData(outDbgData), .outWbData(outWbData), .outWbValid(outWbValid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] mdl [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] expWb();
        if (inMemtoReg == 2'b01) return inLoadWordDividerMEM;
        if (inMemtoReg == 2'b10) return inPcPlus8;
        return inAluLatch;
    endfunction

    function automatic logic expValid();
        return (inRegWrite === 1'b1) && (inMuxRtRd != 5'd0) && (reset === 1'b0);
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (expValid() && a == inMuxRtRd) return expWb();
        return mdl[a];
    endfunction

    task automatic checkAll(input string tag);
        #1;
        chk({tag, " wbData"}, outWbData, expWb());
        chk({tag, " wbValid"}, {31'd0, outWbValid}, {31'd0, expValid()});
        chk({tag, " rs"}, outRsData, expRead(inReadRs));
        chk({tag, " rt"}, outRtData, expRead(inReadRt));
        chk({tag, " dbg"}, outDbgData, expRead(inDbgAddr));
    endtask

    // Advance one clock, updating the model from the inputs held at the edge.
    task automatic step();
        logic        doRst, doWr;
        logic [4:0]  d;
        logic [31:0] w;
        doRst = reset;
        doWr  = expValid();
        d     = inMuxRtRd;
        w     = expWb();
        @(posedge clk);
        if (doRst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (doWr) begin
            mdl[d] = w;
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] dst,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc8);
        inRegWrite = we; inMemtoReg = sel; inMuxRtRd = dst;
        inAluLatch = alu; inLoadWordDividerMEM = ld; inPcPlus8 = pc8;
    endtask

    task automatic reads(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
        inReadRs = rs; inReadRt = rt; inDbgAddr = dbg;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] alu, ld, pc8;
        logic [4:0]  dst;
        logic        we;
        logic [31:0] expWbData;
        logic        expWbValid;
        logic [4:0]  rbAddr;
        logic [31:0] rbExp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{2'b00, 32'h11, 32'hAA, 32'hBB, 5'd3, 1'b1, 32'h11, 1'b1, 5'd3, 32'h11};
        tbl[1] = '{2'b01, 32'h99, 32'h22, 32'hBB, 5'd3, 1'b1, 32'h22, 1'b1, 5'd3, 32'h22};
        tbl[2] = '{2'b10, 32'h99, 32'hAA, 32'h33, 5'd3, 1'b1, 32'h33, 1'b1, 5'd3, 32'h33};
        tbl[3] = '{2'b11, 32'h44, 32'hAA, 32'hBB, 5'd3, 1'b1, 32'h44, 1'b1, 5'd3, 32'h44};
        tbl[4] = '{2'b00, 32'hFFFF_FFFF, 32'h1, 32'h2, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0};
        tbl[5] = '{2'b10, 32'h1, 32'h2, 32'h1234, 5'd10, 1'b0, 32'h1234, 1'b0, 5'd10, 32'h0};
        tbl[6] = '{2'b01, 32'h7, 32'hCAFE_F00D, 32'h8, 5'd31, 1'b1, 32'hCAFE_F00D, 1'b1, 5'd31, 32'hCAFE_F00D};
        tbl[7] = '{2'b00, 32'h5, 32'h6, 32'h7, 5'd1, 1'b1, 32'h5, 1'b1, 5'd1, 32'h5};

        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        reads(5'd0, 5'd0, 5'd0);

        // Reset with a pending write that must be discarded.
        reset = 1'b1;
        drive(1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
        #1;
        chk("reset wbValid", {31'd0, outWbValid}, 32'd0);
        step();
        reset = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        reads(5'd5, 5'd5, 5'd5);
        #1;
        chk("after reset rs5", outRsData, 32'd0);
        chk("after reset dbg5", outDbgData, 32'd0);

        // Table vectors: combinational mux/valid, same-cycle bypass, readback.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].we, tbl[i].sel, tbl[i].dst, tbl[i].alu, tbl[i].ld, tbl[i].pc8);
            reads(tbl[i].dst, tbl[i].dst, tbl[i].dst);
            #1;
            chk($sformatf("vec%0d wbData", i), outWbData, tbl[i].expWbData);
            chk($sformatf("vec%0d wbValid", i), {31'd0, outWbValid}, {31'd0, tbl[i].expWbValid});
            checkAll($sformatf("vec%0d", i));
            step();
            drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
            reads(5'd0, tbl[i].rbAddr, 5'd0);
            #1;
            chk($sformatf("vec%0d readback", i), outRtData, tbl[i].rbExp);
        end

        // Write-first bypass on all three ports at once.
        drive(1'b1, 2'b00, 5'd7, 32'hA, 32'h0, 32'h0);
        step();
        drive(1'b1, 2'b00, 5'd7, 32'hB, 32'h0, 32'h0);
        reads(5'd7, 5'd7, 5'd7);
        #1;
        chk("bypass rs", outRsData, 32'hB);
        chk("bypass rt", outRtData, 32'hB);
        chk("bypass dbg", outDbgData, 32'hB);
        step();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("bypass after rs", outRsData, 32'hB);

        // Disabled write held for three cycles, then X select with no write.
        drive(1'b1, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0);
        step();
        drive(1'b0, 2'b00, 5'd9, 32'h66, 32'h0, 32'h0);
        reads(5'd9, 5'd9, 5'd9);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("nowrite wbData", outWbData, 32'h66);
            chk("nowrite wbValid", {31'd0, outWbValid}, 32'd0);
            chk("nowrite rs9", outRsData, 32'h55);
            step();
        end
        inMemtoReg = 2'bxx;
        step();
        #1;
        chk("xsel rt9", outRtData, 32'h55);
        inMemtoReg = 2'b00;

        // Fill every register and read it back on all ports.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 2'b00, 5'(i), i * 32'h0101_0101, 32'h0, 32'h0);
            step();
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            reads(5'(a), 5'(31 - a), 5'(a));
            #1;
            chk($sformatf("fill rs%0d", a), outRsData, a * 32'h0101_0101);
            chk($sformatf("fill rt%0d", 31 - a), outRtData, (31 - a) * 32'h0101_0101);
            chk($sformatf("fill dbg%0d", a), outDbgData, a * 32'h0101_0101);
        end

        // Reset with a conflicting write: stored value visible, no bypass.
        reset = 1'b1;
        drive(1'b1, 2'b00, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
        reads(5'd5, 5'd5, 5'd5);
        #1;
        chk("in reset rs5", outRsData, 32'h0505_0505);
        chk("in reset wbValid", {31'd0, outWbValid}, 32'd0);
        step();
        reset = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            reads(5'(a), 5'(a), 5'(a));
            #1;
            chk($sformatf("cleared rs%0d", a), outRsData, 32'd0);
            chk($sformatf("cleared dbg%0d", a), outDbgData, 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] dst;
            dst = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom), dst,
                  $urandom, $urandom, $urandom);
            reads(($urandom_range(0, 2) == 0) ? dst : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? dst : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? dst : 5'($urandom));
            checkAll($sformatf("rand%0d", n));
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
